// File: rtl/adder_pkg.sv
// Shared types and saturation helpers for the pipelined add/subtract unit.
package adder_pkg;

    typedef struct packed {
        logic sub;
        logic is_signed;
    } add_mode_t;

    // A saturation word is one MSB followed by NUM_BITS-1 copies of a fill bit.
    typedef struct packed {
        logic msb;
        logic rest;
    } sat_pat_t;

    function automatic sat_pat_t sat_max(input logic is_signed);
        sat_pat_t p;
        p.msb  = !is_signed;
        p.rest = 1'b1;
        return p;
    endfunction

    function automatic sat_pat_t sat_min(input logic is_signed);
        sat_pat_t p;
        p.msb  = is_signed;
        p.rest = 1'b0;
        return p;
    endfunction

    // Signed overflow direction follows the sign of a; unsigned follows add/sub.
    function automatic sat_pat_t sat_pick(input logic is_signed, input logic sub,
                                          input logic a_msb);
        return (is_signed ? a_msb : sub) ? sat_min(is_signed) : sat_max(is_signed);
    endfunction

endpackage

// File: rtl/adder_pipe_stage.sv
// Combinational slice adder; msb_cin is the carry into the slice MSB.
module adder_pipe_stage #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             msb_cin
);
    logic [WIDTH:0] full;

    assign full    = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    assign s       = full[WIDTH-1:0];
    assign cout    = full[WIDTH];
    assign msb_cin = a[WIDTH-1] ^ b[WIDTH-1] ^ full[WIDTH-1];
endmodule

// File: rtl/adder_pipelined.sv
// Pipelined add/subtract: one CHUNK_BITS slice per stage, carry registered between
// stages, valid/ready flow control with backpressure and optional saturation.
module adder_pipelined
    import adder_pkg::*;
#(
    parameter int NUM_BITS   = 32,
    parameter int CHUNK_BITS = 8,
    parameter int SATURATE   = 0
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [NUM_BITS-1:0] a,
    input  logic [NUM_BITS-1:0] b,
    input  logic                carry_in,
    input  logic                sub,
    input  logic                is_signed,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [NUM_BITS-1:0] sum,
    output logic                carry_out,
    output logic                overflow
);
    localparam int STAGES = NUM_BITS / CHUNK_BITS;
    localparam int LAST   = STAGES - 1;

    logic [STAGES-1:0]     vld;
    logic [STAGES-1:0]     adv;
    logic [STAGES-1:0]     vld_in;

    logic [NUM_BITS-1:0]   a_q    [STAGES];
    logic [NUM_BITS-1:0]   b_q    [STAGES];
    logic [NUM_BITS-1:0]   r_q    [STAGES];
    logic                  c_q    [STAGES];
    add_mode_t             mode_q [STAGES];

    logic [NUM_BITS-1:0]   a_in    [STAGES];
    logic [NUM_BITS-1:0]   b_in    [STAGES];
    logic [NUM_BITS-1:0]   r_in    [STAGES];
    logic [NUM_BITS-1:0]   r_nxt   [STAGES];
    logic                  cin_in  [STAGES];
    add_mode_t             mode_in [STAGES];

    logic [CHUNK_BITS-1:0] sl_s       [STAGES];
    logic                  sl_cout    [STAGES];
    logic                  sl_msb_cin [STAGES];

    add_mode_t             mode_fin;
    sat_pat_t              sat_pat;
    logic                  ovf_fin;
    logic [NUM_BITS-1:0]   sum_fin;

    // A stage may load when it is empty or anything downstream of it can move.
    always_comb begin
        logic run;
        run = out_ready;
        adv = '0;
        for (int k = LAST; k >= 0; k--) begin
            run    = run || !vld[k];
            adv[k] = run;
        end
    end

    assign in_ready  = adv[0];
    assign out_valid = vld[LAST];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign a_in[k]    = a;
            assign b_in[k]    = sub ? ~b : b;
            assign cin_in[k]  = sub | carry_in;
            assign mode_in[k] = '{sub: sub, is_signed: is_signed};
            assign r_in[k]    = '0;
            assign vld_in[k]  = in_valid;
        end else begin : g_body
            assign a_in[k]    = a_q[k-1];
            assign b_in[k]    = b_q[k-1];
            assign cin_in[k]  = c_q[k-1];
            assign mode_in[k] = mode_q[k-1];
            assign r_in[k]    = r_q[k-1];
            assign vld_in[k]  = vld[k-1];
        end

        adder_pipe_stage #(.WIDTH(CHUNK_BITS)) u_slice (
            .a       (a_in[k][k*CHUNK_BITS +: CHUNK_BITS]),
            .b       (b_in[k][k*CHUNK_BITS +: CHUNK_BITS]),
            .cin     (cin_in[k]),
            .s       (sl_s[k]),
            .cout    (sl_cout[k]),
            .msb_cin (sl_msb_cin[k])
        );

        // Bits above the current slice are always zero in r_in, so OR places the slice.
        assign r_nxt[k] = r_in[k] | (NUM_BITS'(sl_s[k]) << (k * CHUNK_BITS));
    end

    assign mode_fin = mode_in[LAST];

    always_comb begin
        ovf_fin = mode_fin.is_signed ? (sl_cout[LAST] ^ sl_msb_cin[LAST])
                                     : (sl_cout[LAST] ^ mode_fin.sub);
        sat_pat = sat_pick(mode_fin.is_signed, mode_fin.sub, a_in[LAST][NUM_BITS-1]);
        sum_fin = r_nxt[LAST];
        if ((SATURATE != 0) && ovf_fin) begin
            sum_fin = {sat_pat.msb, {(NUM_BITS-1){sat_pat.rest}}};
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            vld       <= '0;
            sum       <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            for (int k = 0; k < LAST; k++) begin
                a_q[k]    <= '0;
                b_q[k]    <= '0;
                r_q[k]    <= '0;
                c_q[k]    <= 1'b0;
                mode_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (adv[k]) begin
                    vld[k] <= vld_in[k];
                end
            end
            // Data only moves with a valid op so idle registers stay stable.
            for (int k = 0; k < LAST; k++) begin
                if (adv[k] && vld_in[k]) begin
                    a_q[k]    <= a_in[k];
                    b_q[k]    <= b_in[k];
                    r_q[k]    <= r_nxt[k];
                    c_q[k]    <= sl_cout[k];
                    mode_q[k] <= mode_in[k];
                end
            end
            if (adv[LAST] && vld_in[LAST]) begin
                sum       <= sum_fin;
                carry_out <= sl_cout[LAST];
                overflow  <= ovf_fin;
            end
        end
    end
endmodule

// File: tb/tb_adder_pipelined.sv
// Bench for adder_pipelined: wrapping and saturating instances share stimulus and
// are checked against an integer-arithmetic reference with an in-order scoreboard.
module tb_adder_pipelined;
    localparam int NB     = 32;
    localparam int CB     = 8;
    localparam int STAGES = NB / CB;

    localparam longint U_MAX = 64'sd4294967295;
    localparam longint S_MAX = 64'sd2147483647;
    localparam longint S_MIN = -64'sd2147483648;

    logic          clk = 1'b0;
    logic          n_rst = 1'b0;
    logic          in_valid, out_ready;
    logic [NB-1:0] a, b;
    logic          carry_in, sub, is_signed;

    logic          in_ready, out_valid, carry_out, overflow;
    logic [NB-1:0] sum;
    logic          in_ready_s, out_valid_s, carry_out_s, overflow_s;
    logic [NB-1:0] sum_s;

    always #5 clk = ~clk;

    adder_pipelined #(.NUM_BITS(NB), .CHUNK_BITS(CB), .SATURATE(0)) u_dut (
        .clk(clk), .n_rst(n_rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .carry_in(carry_in), .sub(sub), .is_signed(is_signed),
        .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
        .carry_out(carry_out), .overflow(overflow)
    );

    adder_pipelined #(.NUM_BITS(NB), .CHUNK_BITS(CB), .SATURATE(1)) u_sat (
        .clk(clk), .n_rst(n_rst), .in_valid(in_valid), .in_ready(in_ready_s),
        .a(a), .b(b), .carry_in(carry_in), .sub(sub), .is_signed(is_signed),
        .out_valid(out_valid_s), .out_ready(out_ready), .sum(sum_s),
        .carry_out(carry_out_s), .overflow(overflow_s)
    );

    typedef struct {
        logic [31:0] s_wrap;
        logic [31:0] s_sat;
        logic        co;
        logic        ov;
        int          acc_edge;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    int          edge_no = 0;
    int          n_out = 0;
    int          last_lat = 0;
    logic        acc_flag = 1'b0;
    logic        ready_low_seen = 1'b0;
    logic [31:0] last_sum, last_sum_s;
    logic        last_co, last_ov;

    function automatic exp_t model(input logic [31:0] av, input logic [31:0] bv,
                                   input logic cv, input logic sv, input logic gv);
        exp_t   e;
        longint ua, ub, ut, sa, sbv, st;
        ua  = longint'(av);
        ub  = longint'(bv);
        sa  = longint'($signed(av));
        sbv = longint'($signed(bv));
        if (sv) begin
            ut = ua - ub;
            st = sa - sbv;
        end else begin
            ut = ua + ub + longint'(cv);
            st = sa + sbv + longint'(cv);
        end
        e.s_wrap   = ut[31:0];
        e.co       = sv ? (ua >= ub) : (ut > U_MAX);
        e.ov       = gv ? ((st > S_MAX) || (st < S_MIN)) : ((ut > U_MAX) || (ut < 0));
        if (!e.ov)      e.s_sat = e.s_wrap;
        else if (gv)    e.s_sat = (st > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
        else            e.s_sat = sv ? 32'h0000_0000 : 32'hFFFF_FFFF;
        e.acc_edge = 0;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Evaluate both handshakes just before the coming rising edge, then step past it.
    task automatic cycle();
        exp_t e;
        @(negedge clk);
        acc_flag = in_valid && in_ready;
        if (in_valid && !in_ready) ready_low_seen = 1'b1;
        if (out_valid && out_ready) begin
            chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            chk("sat_valid", 32'(out_valid_s), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("sum", sum, e.s_wrap);
                chk("sum_sat", sum_s, e.s_sat);
                chk("carry_out", 32'(carry_out), 32'(e.co));
                chk("overflow", 32'(overflow), 32'(e.ov));
                last_lat = edge_no + 1 - e.acc_edge;
            end
            n_out++;
            last_sum   = sum;
            last_sum_s = sum_s;
            last_co    = carry_out;
            last_ov    = overflow;
        end
        if (acc_flag) begin
            e = model(a, b, carry_in, sub, is_signed);
            e.acc_edge = edge_no + 1;
            sb.push_back(e);
        end
        @(posedge clk);
        edge_no++;
        #1;
    endtask

    task automatic new_op();
        a         = $urandom();
        b         = $urandom();
        carry_in  = 1'($urandom_range(0, 1));
        sub       = 1'($urandom_range(0, 1));
        is_signed = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 7))
            0: a = 32'hFFFF_FFFF;
            1: a = 32'h7FFF_FFFF;
            2: a = 32'h8000_0000;
            3: b = 32'h0000_0000;
            default: ;
        endcase
    endtask

    task automatic send(input logic [31:0] av, input logic [31:0] bv, input logic cv,
                        input logic sv, input logic gv);
        a = av; b = bv; carry_in = cv; sub = sv; is_signed = gv;
        in_valid = 1'b1;
        acc_flag = 1'b0;
        for (int i = 0; i < 50 && !acc_flag; i++) cycle();
        chk("send_accepted", 32'(acc_flag), 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain(input int budget);
        out_ready = 1'b1;
        for (int i = 0; i < budget && sb.size() != 0; i++) cycle();
        chk("drain_empty", sb.size(), 32'd0);
    endtask

    task automatic reset_mid_cycle();
        #2;
        n_rst = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sum", sum, 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_carry_out", 32'(carry_out), 32'd0);
        chk("rst_sat_valid", 32'(out_valid_s), 32'd0);
        sb.delete();
        @(negedge clk);
        n_rst = 1'b1;
        @(posedge clk);
        edge_no++;
        #1;
        chk("rel_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        int sent, stall, base;
        logic stalled_once;
        in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; carry_in = 1'b0; sub = 1'b0; is_signed = 1'b0;

        #12;
        chk("init_out_valid", 32'(out_valid), 32'd0);
        chk("init_sum", sum, 32'd0);
        chk("init_overflow", 32'(overflow), 32'd0);
        @(negedge clk);
        n_rst = 1'b1;
        @(posedge clk);
        edge_no++;
        #1;
        chk("init_in_ready", 32'(in_ready), 32'd1);

        // Unsigned wrap at all ones, with latency measured from the accept edge.
        send(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b0);
        drain(20);
        chk("latency", last_lat, STAGES);
        chk("t2_sum", last_sum, 32'h0);
        chk("t2_carry", 32'(last_co), 32'd1);
        chk("t2_ovf", 32'(last_ov), 32'd1);

        send(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b1);
        drain(20);
        chk("t3_sum", last_sum, 32'h8000_0000);
        chk("t3_ovf", 32'(last_ov), 32'd1);
        chk("t3_sat", last_sum_s, 32'h7FFF_FFFF);

        send(32'h5, 32'h7, 1'b0, 1'b1, 1'b0);
        drain(20);
        chk("t4_sum", last_sum, 32'hFFFF_FFFE);
        chk("t4_carry", 32'(last_co), 32'd0);
        chk("t4_ovf", 32'(last_ov), 32'd1);
        chk("t4_sat", last_sum_s, 32'h0);
        send(32'h5, 32'h7, 1'b1, 1'b1, 1'b1);
        drain(20);
        chk("t4s_sum", last_sum, 32'hFFFF_FFFE);
        chk("t4s_ovf", 32'(last_ov), 32'd0);

        // Fill the pipe behind a stalled output, then reset between edges.
        out_ready = 1'b0;
        for (int i = 0; i < STAGES; i++) send($urandom(), $urandom(), 1'b0, 1'b0, 1'b0);
        chk("full_out_valid", 32'(out_valid), 32'd1);
        reset_mid_cycle();
        out_ready = 1'b1;

        // Stream 8 ops and hold the output for 3 cycles after the second result.
        sent = 0; stall = 0; stalled_once = 1'b0; base = n_out; ready_low_seen = 1'b0;
        new_op();
        for (int i = 0; i < 80 && (sent < 8 || sb.size() != 0); i++) begin
            in_valid  = (sent < 8);
            out_ready = (stall == 0);
            cycle();
            if (acc_flag) begin
                sent++;
                new_op();
            end
            if (stall > 0) stall--;
            else if (!stalled_once && (n_out - base) == 2) begin
                stall = 3;
                stalled_once = 1'b1;
            end
        end
        in_valid = 1'b0;
        chk("t5_count", n_out - base, 32'd8);
        chk("t5_sb_empty", sb.size(), 32'd0);
        chk("t5_ready_fell", 32'(ready_low_seen), 32'd1);

        // Three ops in flight are lost to reset and must never surface.
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) send($urandom(), $urandom(), 1'b1, 1'b0, 1'b1);
        reset_mid_cycle();
        for (int i = 0; i < 10; i++) begin
            cycle();
            chk("post_rst_idle", 32'(out_valid), 32'd0);
        end

        sent = 0;
        new_op();
        for (int i = 0; i < 4000 && sent < 512; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 9) < 7);
            cycle();
            if (acc_flag) begin
                sent++;
                new_op();
            end
        end
        in_valid = 1'b0;
        drain(40);
        chk("random_sent", sent, 32'd512);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
